// File: rtl/controller_pkg.sv
// Shared definitions for the controller port: scanner states and the bit
// position of each button in the buttons byte.
package controller_pkg;

  // Scanner FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    CLK_HI = 3'd2,
    CLK_LO = 3'd3,
    DONE   = 3'd4
  } scan_state_e;

  // Button bit positions within buttons (active-high)
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/controller_scanner.sv
// Periodic scanner for an external 4021-based pad: latches the pad, clocks out
// eight serial bits, and publishes them as one atomic byte with a done pulse.
module controller_scanner #(
  parameter int HALF_PERIOD   = 300,
  parameter int SCAN_INTERVAL = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       scan_done
);
  import controller_pkg::*;

  localparam int                PH_W       = $clog2(2 * HALF_PERIOD);
  localparam int                INT_W      = $clog2(SCAN_INTERVAL);
  localparam logic [PH_W-1:0]   LATCH_LAST = PH_W'(2 * HALF_PERIOD - 1);
  localparam logic [PH_W-1:0]   HALF_LAST  = PH_W'(HALF_PERIOD - 1);
  localparam logic [INT_W-1:0]  INT_LAST   = INT_W'(SCAN_INTERVAL - 1);

  scan_state_e      r_state;
  scan_state_e      w_next_state;
  logic             w_sample_en;
  logic             r_sync1;
  logic             r_sync2;
  logic [INT_W-1:0] r_int_cnt;
  logic [PH_W-1:0]  r_phase;
  logic [2:0]       r_bit_cnt;
  logic [6:0]       r_sample;
  logic [7:0]       r_buttons;
  logic             r_scan_done;
  logic             r_pad_latch;
  logic             r_pad_clk;

  // Two-flop synchronizer for the asynchronous pad data pin (idles high)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= pad_data;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running interval counter; a scan starts whenever it reads zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_int_cnt <= {INT_W{1'b0}};
    end else if (r_int_cnt == INT_LAST) begin
      r_int_cnt <= {INT_W{1'b0}};
    end else begin
      r_int_cnt <= r_int_cnt + INT_W'(1);
    end
  end

  // Next-state decode; also flags the edges on which a pad bit is captured
  always_comb begin
    w_next_state = r_state;
    w_sample_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_int_cnt == {INT_W{1'b0}}) begin
          w_next_state = LATCH;
        end else begin
          w_next_state = IDLE;
        end
      end
      LATCH: begin
        if (r_phase == LATCH_LAST) begin
          w_next_state = CLK_HI;
          w_sample_en  = 1'b1;
        end else begin
          w_next_state = LATCH;
        end
      end
      CLK_HI: begin
        if (r_phase == HALF_LAST) begin
          w_next_state = CLK_LO;
        end else begin
          w_next_state = CLK_HI;
        end
      end
      CLK_LO: begin
        if (r_phase == HALF_LAST) begin
          w_sample_en = 1'b1;
          if (r_bit_cnt == 3'd7) begin
            w_next_state = DONE;
          end else begin
            w_next_state = CLK_HI;
          end
        end else begin
          w_next_state = CLK_LO;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register plus registered pad pins and done pulse, all decoded from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pad_latch <= 1'b0;
      r_pad_clk   <= 1'b0;
      r_scan_done <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_pad_latch <= (w_next_state == LATCH);
      r_pad_clk   <= (w_next_state == CLK_HI);
      r_scan_done <= (w_next_state == DONE);
    end
  end

  // Phase counter measures time spent in the current state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= {PH_W{1'b0}};
    end else if ((w_next_state != r_state) || (r_state == IDLE)) begin
      r_phase <= {PH_W{1'b0}};
    end else begin
      r_phase <= r_phase + PH_W'(1);
    end
  end

  // Bit index: 0 during LATCH, then counts each CLK_LO exit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt <= 3'd0;
    end else if (r_state == IDLE) begin
      r_bit_cnt <= 3'd0;
    end else if (w_sample_en) begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end else begin
      r_bit_cnt <= r_bit_cnt;
    end
  end

  // Collect inverted pad bits LSB-first; bit 7 goes straight into buttons with the rest
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample  <= 7'd0;
      r_buttons <= 8'h00;
    end else if (w_sample_en) begin
      r_sample <= {~r_sync2, r_sample[6:1]};
      if (w_next_state == DONE) begin
        r_buttons <= {~r_sync2, r_sample};
      end else begin
        r_buttons <= r_buttons;
      end
    end else begin
      r_sample  <= r_sample;
      r_buttons <= r_buttons;
    end
  end

  assign pad_latch = r_pad_latch;
  assign pad_clk   = r_pad_clk;
  assign buttons   = r_buttons;
  assign scan_done = r_scan_done;

endmodule

// File: rtl/controller_port.sv
// CPU-facing $4016 controller port: strobe register and serial shift register
// fed from the background pad scanner.
module controller_port #(
  parameter int HALF_PERIOD   = 300,
  parameter int SCAN_INTERVAL = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_wr,
  input  logic       cpu_wdata,
  input  logic       cpu_rd,
  output logic       cpu_rdata,
  output logic       pad_latch,
  output logic       pad_clk,
  input  logic       pad_data,
  output logic [7:0] buttons,
  output logic       scan_done
);
  import controller_pkg::*;

  logic [7:0] w_buttons;
  logic       r_strobe;
  logic [7:0] r_shift;

  controller_scanner #(
    .HALF_PERIOD  (HALF_PERIOD),
    .SCAN_INTERVAL(SCAN_INTERVAL)
  ) u_scanner (
    .clk      (clk),
    .reset    (reset),
    .pad_data (pad_data),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk),
    .buttons  (w_buttons),
    .scan_done(scan_done)
  );

  // Strobe bit follows CPU writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_strobe <= 1'b0;
    end else if (cpu_wr) begin
      r_strobe <= cpu_wdata;
    end else begin
      r_strobe <= r_strobe;
    end
  end

  // Shift register: reloads while strobe is high (pre-edge value), otherwise reads shift in ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= 8'h00;
    end else if (r_strobe) begin
      r_shift <= w_buttons;
    end else if (cpu_rd) begin
      r_shift <= {1'b1, r_shift[7:1]};
    end else begin
      r_shift <= r_shift;
    end
  end

  assign cpu_rdata = r_shift[0];
  assign buttons   = w_buttons;

endmodule

// File: tb/tb_controller_port.sv
// Scoreboard bench for controller_port with a behavioural 4021 pad model.
module tb_controller_port;
  import controller_pkg::*;

  localparam int HP = 4;
  localparam int SI = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_wr = 1'b0;
  logic       cpu_wdata = 1'b0;
  logic       cpu_rd = 1'b0;
  logic       cpu_rdata;
  logic       pad_latch;
  logic       pad_clk;
  logic       pad_data;
  logic [7:0] buttons;
  logic       scan_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] btn_q[$];
  logic       rd_q[$];
  logic [7:0] mon_btn_exp;
  logic       mon_rd_exp;

  logic [7:0] pad_bits = 8'hFF;
  logic [7:0] pad_byte = 8'hFF;
  logic [3:0] pad_idx = 4'd8;
  logic       prev_pclk = 1'b0;
  logic       prev_plat = 1'b0;

  int cyc, lat, pul, k;
  logic rd_seq [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  controller_port #(.HALF_PERIOD(HP), .SCAN_INTERVAL(SI)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_wr   (cpu_wr),
    .cpu_wdata(cpu_wdata),
    .cpu_rd   (cpu_rd),
    .cpu_rdata(cpu_rdata),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk),
    .pad_data (pad_data),
    .buttons  (buttons),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // 4021 pad model: parallel load while latched, advance on pad_clk rise; expected buttons queued at latch
  always @(posedge clk) begin
    prev_pclk <= pad_clk;
    prev_plat <= pad_latch;
    if (pad_latch) begin
      pad_idx  <= 4'd0;
      pad_byte <= pad_bits;
    end else if (pad_clk && !prev_pclk && (pad_idx < 4'd8)) begin
      pad_idx <= pad_idx + 4'd1;
    end
    if (pad_latch && !prev_plat) btn_q.push_back(~pad_bits);
  end
  assign pad_data = (pad_idx < 4'd8) ? pad_byte[pad_idx[2:0]] : 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: compare every CPU read and every published scan against the scoreboard
  always @(negedge clk) begin
    if (!reset && cpu_rd) begin
      if (rd_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_unexpected: read with no expected value at %0t", $time);
      end else begin
        mon_rd_exp = rd_q.pop_front();
        check("cpu_rdata", int'(cpu_rdata), int'(mon_rd_exp));
      end
    end
    if (!reset && scan_done) begin
      if (btn_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL scan_unexpected: scan_done with buttons 0x%0h and no expected scan at %0t", buttons, $time);
      end else begin
        mon_btn_exp = btn_q.pop_front();
        check("buttons", int'(buttons), int'(mon_btn_exp));
      end
    end
  end

  task automatic wait_done(output int c, output int l, output int p);
    logic prev;
    c = 0; l = 0; p = 0; prev = 1'b0;
    do begin
      @(posedge clk); #1;
      c++;
      if (pad_latch) l++;
      if (pad_clk && !prev) p++;
      prev = pad_clk;
    end while (!scan_done && c < 300);
    if (!scan_done) begin
      n_checks++; n_fail++;
      $display("FAIL scan_timeout: no scan_done within %0d cycles", c);
    end
  endtask

  task automatic cpu_write(input logic v);
    cpu_wr = 1'b1; cpu_wdata = v;
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_wdata = 1'b0;
  endtask

  task automatic cpu_read(input logic e);
    cpu_rd = 1'b1; rd_q.push_back(e);
    @(posedge clk); #1;
    cpu_rd = 1'b0;
  endtask

  task automatic cpu_wr_rd(input logic v, input logic e);
    cpu_wr = 1'b1; cpu_wdata = v; cpu_rd = 1'b1; rd_q.push_back(e);
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_wdata = 1'b0; cpu_rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Directed stimulus
  initial begin
    pad_bits = 8'hFE;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_buttons", int'(buttons), 0);
    check("rst_scan_done", int'(scan_done), 0);
    check("rst_pad_latch", int'(pad_latch), 0);
    check("rst_pad_clk", int'(pad_clk), 0);
    check("rst_cpu_rdata", int'(cpu_rdata), 0);

    // First scan: A pressed
    @(negedge clk); reset = 1'b0;
    wait_done(cyc, lat, pul);
    check("first_done_cycle", cyc, 65);
    check("latch_cycles", lat, 8);
    check("pad_clk_pulses", pul, 7);
    check("btn_a", int'(buttons[BTN_A]), 1);

    // buttons = 0x81, strobe 1 then 0, ten reads
    pad_bits = 8'h7E;
    wait_done(cyc, lat, pul);
    cpu_write(1'b1);
    cpu_write(1'b0);
    for (int i = 0; i < 10; i++) cpu_read(rd_seq[i]);

    // buttons = 0x01, reads with strobe held high do not shift
    pad_bits = 8'hFE;
    wait_done(cyc, lat, pul);
    pad_bits = 8'hFF;
    cpu_write(1'b1);
    idle(1);
    repeat (3) cpu_read(1'b1);
    cpu_write(1'b0);
    cpu_read(1'b1);
    cpu_read(1'b0);

    // Scan to 0x00 completes mid-readout; remaining reads follow the frozen byte
    wait_done(cyc, lat, pul);
    pad_bits = 8'hFC;
    repeat (6) cpu_read(1'b0);
    cpu_read(1'b1);
    cpu_read(1'b1);
    cpu_write(1'b1);
    idle(1);
    cpu_read(1'b0);

    // buttons = 0x03; write+read in the same cycle with strobe low
    wait_done(cyc, lat, pul);
    cpu_write(1'b0);
    cpu_read(1'b1);
    cpu_wr_rd(1'b1, 1'b1);
    cpu_read(1'b0);
    cpu_read(1'b1);

    // Reset at cycle 30 of a scan
    k = 0;
    while (!pad_latch && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (!pad_latch) begin
      n_checks++; n_fail++;
      $display("FAIL latch_timeout: no scan start within %0d cycles", k);
    end
    repeat (29) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_pad_latch", int'(pad_latch), 0);
    check("midrst_pad_clk", int'(pad_clk), 0);
    check("midrst_buttons", int'(buttons), 0);
    check("midrst_scan_done", int'(scan_done), 0);
    check("midrst_cpu_rdata", int'(cpu_rdata), 0);
    btn_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    wait_done(cyc, lat, pul);
    check("rescan_done_cycle", cyc, 65);
    check("rescan_latch_cycles", lat, 8);
    check("rescan_pulses", pul, 7);

    idle(2);
    check("queues_drained", rd_q.size() + btn_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controller_port.md
CONTROLLER_PORT -- requirements
Module: controller_port

Interface
REQ-001 Parameter HALF_PERIOD, 300, clk cycles per pad_clk half-period; legal values are >= 4.
REQ-002 Parameter SCAN_INTERVAL, 833333, clk cycles between scan starts; legal values are > 16*HALF_PERIOD+2.
REQ-003 clk  in  1  system clock; all logic is on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cpu_wr  in  1  single-cycle CPU write strobe to $4016.
REQ-006 cpu_wdata  in  1  written data bit 0, which is the strobe value.
REQ-007 cpu_rd  in  1  single-cycle CPU read strobe of $4016.
REQ-008 cpu_rdata  out  1  serial button bit returned to the CPU.
REQ-009 pad_latch  out  1  latch pin to the external 4021 pad.
REQ-010 pad_clk  out  1  clock pin to the external 4021 pad.
REQ-011 pad_data  in  1  serial data pin from the pad; asynchronous and active-low.
REQ-012 buttons  out  8  last completed scan, active-high; bit order [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
REQ-013 scan_done  out  1  one-cycle pulse when buttons updates.

Function
REQ-014 pad_data SHALL pass through a 2-FF synchronizer before any use.
REQ-015 The scanner FSM SHALL have the states IDLE, LATCH, CLK_HI, CLK_LO and DONE.
REQ-016 An interval counter SHALL start a scan (IDLE->LATCH) every SCAN_INTERVAL cycles.
REQ-017 The first scan SHALL start on the first clk edge after reset deasserts.
REQ-018 In LATCH, pad_latch SHALL be 1 for exactly 2*HALF_PERIOD cycles.
REQ-019 Bit 0 SHALL be sampled as the inverted synchronized pad_data on the cycle that LATCH exits to CLK_HI.
REQ-020 CLK_HI SHALL last HALF_PERIOD cycles with pad_clk=1.
REQ-021 CLK_LO SHALL last HALF_PERIOD cycles with pad_clk=0.
REQ-022 Bit i (i=1..7) SHALL be sampled on the exit of the i-th CLK_LO state, giving 7 pad_clk pulses per scan.
REQ-023 After bit 7, the FSM SHALL enter DONE for 1 cycle, copy the sampled byte to buttons atomically, pulse scan_done, then return to IDLE.
REQ-024 Total scan length SHALL be 16*HALF_PERIOD+1 cycles; buttons SHALL NOT change mid-scan.
REQ-025 strobe SHALL be a 1-bit register loaded from cpu_wdata when cpu_wr=1.
REQ-026 While strobe=1, the 8-bit CPU shift register SHALL reload from buttons every cycle, and cpu_rd SHALL NOT shift it.
REQ-027 cpu_rdata SHALL be combinationally equal to shift-register bit 0 (zero read latency).
REQ-028 While strobe=0, cpu_rd SHALL shift the register right by one at the clock edge with 1 filled into bit 7.
REQ-029 After 8 reads with strobe=0, all further reads SHALL return 1.
REQ-030 If cpu_wr and cpu_rd occur in the same cycle, the read SHALL return the pre-edge bit 0; the write then takes effect, and the shift occurs only if the pre-edge strobe=0.
REQ-031 A scan completing while strobe=0 SHALL update buttons only, never the shift register.
REQ-032 A strobe 1->0 transition SHALL freeze the value loaded in the last strobe=1 cycle.

Reset
REQ-033 On reset: FSM=IDLE, counters=0, pad_latch=0, pad_clk=0, scan_done=0, buttons=8'h00, strobe=0, shift register=8'h00 (so cpu_rdata=0), synchronizer flops=1.
REQ-034 Reset asserted mid-scan SHALL abort the scan immediately with buttons unchanged from reset value and pins low, and SHALL NOT pulse scan_done.

Structure
REQ-035 Package controller_pkg SHALL hold the scanner state enum and the button index constants BTN_A..BTN_RIGHT.
REQ-036 Sub-module controller_scanner SHALL contain the synchronizer, FSM, interval/phase counters and the buttons register.
REQ-037 controller_port SHALL contain the strobe register, the CPU shift register and the sub-module instance.

Verification (HALF_PERIOD=4, SCAN_INTERVAL=100)
REQ-038 Pad model drives byte 8'b1111_1110 (A pressed, active-low) -> buttons=8'h01 and a scan_done pulse 65 cycles after reset release; pad_latch high for 8 cycles; exactly 7 pad_clk pulses.
REQ-039 buttons=8'h81; write strobe 1 then 0; 10 reads -> cpu_rdata sequence 1,0,0,0,0,0,0,1,1,1.
REQ-040 strobe held 1; 3 reads with buttons=8'h01 -> each read returns 1 and no shift occurs.
REQ-041 strobe=0 with 2 reads done; scan completes with new buttons=8'h00 -> remaining reads follow the old byte until the next strobe.
REQ-042 Reset asserted at cycle 30 of a scan -> pins go 0 immediately, buttons=8'h00, no scan_done; a new scan starts after release.
REQ-043 cpu_wr(cpu_wdata=1) and cpu_rd in the same cycle with strobe=0 -> old bit 0 is returned, the register shifts once, and reload begins the next cycle.
